// File: rtl/hc_csr_pkg.sv
// Shared types and constants for the HC CSR bank: minimal CCI-P MMIO structs,
// register offsets, control codes and the control FSM state encoding.
package hc_csr_pkg;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [511:0]        data;
        logic                rspValid;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef logic [63:0] t_hc_address;

    typedef struct packed {
        t_hc_address address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef enum logic [2:0] {
        S_CTL_RESET = 3'd0,
        S_CTL_IDLE  = 3'd1,
        S_CTL_RUN   = 3'd2,
        S_CTL_STOP  = 3'd3
    } t_ctl_state;

    // Byte offsets; decode compares against {dword_addr[15:1], 3'b000}.
    localparam logic [17:0] OFF_DFH        = 18'h000;
    localparam logic [17:0] OFF_AFU_ID_L   = 18'h008;
    localparam logic [17:0] OFF_AFU_ID_H   = 18'h010;
    localparam logic [17:0] OFF_HC_STATUS  = 18'h100;
    localparam logic [17:0] OFF_DSM_BASE   = 18'h110;
    localparam logic [17:0] OFF_HC_CONTROL = 18'h118;
    localparam logic [17:0] OFF_BUF_BASE   = 18'h120;
    localparam logic [17:0] OFF_BUF_STRIDE = 18'h010;

    localparam logic [31:0] CTL_RESET = 32'h0;
    localparam logic [31:0] CTL_INIT  = 32'h1;
    localparam logic [31:0] CTL_START = 32'h3;
    localparam logic [31:0] CTL_STOP  = 32'h7;

    localparam logic [63:0] DFH_VALUE = 64'h1000_0000_0000_1000;

    // 8-byte writes replace the register; 4-byte writes carry data in the low
    // dword and land in the half chosen by dword address bit 0.
    function automatic logic [63:0] hc_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic        full,
                                             input logic        hi);
        if (full)    return wdata;
        else if (hi) return {wdata[31:0], old_val[31:0]};
        else         return {old_val[63:32], wdata[31:0]};
    endfunction

endpackage

// File: rtl/hc_csr_bank_fsm.sv
// Control FSM: RESET/IDLE/RUN/STOP stepped by HC_CONTROL writes, with
// one-cycle start/stop pulses coincident with the first cycle in RUN/STOP.
module hc_ctl_fsm
    import hc_csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ctl_wr,
    input  logic [31:0] ctl_data,
    output t_ctl_state  state,
    output logic        start,
    output logic        stop
);

    t_ctl_state state_q, state_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CTL_RESET;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ctl_wr) begin
            case (ctl_data)
                CTL_RESET: state_d = S_CTL_RESET;
                CTL_INIT:  if (state_q == S_CTL_RESET) state_d = S_CTL_IDLE;
                CTL_START: if (state_q == S_CTL_IDLE || state_q == S_CTL_STOP) state_d = S_CTL_RUN;
                CTL_STOP:  if (state_q == S_CTL_RUN) state_d = S_CTL_STOP;
                default:   state_d = state_q;
            endcase
        end
        start_d = (state_d == S_CTL_RUN) && (state_q != S_CTL_RUN);
        stop_d  = (state_d == S_CTL_STOP) && (state_q != S_CTL_STOP);
    end

    assign state = state_q;
    assign start = start_q;
    assign stop  = stop_q;

endmodule

// File: rtl/hc_csr_bank.sv
// MMIO CSR bank: AFU header, status, DSM base, buffer descriptors and the
// control register feeding hc_ctl_fsm. Reads answer exactly one cycle later.
module hc_csr_bank
    import hc_csr_pkg::*;
#(
    parameter int           NUM_BUFFERS = 2,
    parameter logic [127:0] AFU_ID      = 128'h0
) (
    input  logic           clk,
    input  logic           SoftReset,
    input  t_if_ccip_c0_Rx rx_c0,
    output t_if_ccip_c2_Tx tx_c2,
    output logic [63:0]    hc_dsm_base,
    output t_hc_buffer     hc_buffer [NUM_BUFFERS],
    output logic           hc_afu_rst,
    output logic           hc_start,
    output logic           hc_stop,
    output logic           hc_running
);

    logic [63:0] dsm_q, dsm_d;
    t_hc_buffer  buf_q [NUM_BUFFERS];
    t_hc_buffer  buf_d [NUM_BUFFERS];
    logic        lock_err_q, lock_err_d;
    logic        rd_valid_q, rd_valid_d;
    logic [8:0]  rd_tid_q, rd_tid_d;
    logic [63:0] rd_data_q, rd_data_d;

    logic [17:0] byte_off;
    logic        wr_en, wr_full, wr_hi, ctl_wr;
    logic [63:0] wr_data;
    t_ctl_state  ctl_state;
    logic        unused_rx;

    assign byte_off  = {rx_c0.hdr.address[15:1], 3'b000};
    assign wr_hi     = rx_c0.hdr.address[0];
    assign wr_full   = (rx_c0.hdr.length != 2'b00);
    assign wr_data   = rx_c0.data[63:0];
    assign wr_en     = rx_c0.mmioWrValid && !rx_c0.mmioRdValid;
    assign unused_rx = ^{rx_c0.hdr.rsvd, rx_c0.data[511:64], rx_c0.rspValid};

    hc_ctl_fsm u_ctl_fsm (
        .clk      (clk),
        .rst      (SoftReset),
        .ctl_wr   (ctl_wr),
        .ctl_data (wr_data[31:0]),
        .state    (ctl_state),
        .start    (hc_start),
        .stop     (hc_stop)
    );

    // Register writes; DSM and buffers are frozen while running.
    always_comb begin
        dsm_d      = dsm_q;
        buf_d      = buf_q;
        lock_err_d = lock_err_q;
        ctl_wr     = 1'b0;
        if (wr_en) begin
            if (byte_off == OFF_HC_CONTROL && (wr_full || !wr_hi)) ctl_wr = 1'b1;
            if (byte_off == OFF_DSM_BASE) begin
                if (ctl_state == S_CTL_RUN) lock_err_d = 1'b1;
                else dsm_d = hc_merge(dsm_q, wr_data, wr_full, wr_hi);
            end
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (byte_off == OFF_BUF_BASE + 18'(16 * i)) begin
                    if (ctl_state == S_CTL_RUN) lock_err_d = 1'b1;
                    else buf_d[i].address = hc_merge(buf_q[i].address, wr_data, wr_full, wr_hi);
                end
                if (byte_off == OFF_BUF_BASE + 18'(16 * i) + 18'h8) begin
                    if (ctl_state == S_CTL_RUN) lock_err_d = 1'b1;
                    else if (wr_full || !wr_hi) buf_d[i].size = wr_data[31:0];
                end
            end
        end
        if (ctl_wr && wr_data[31:0] == CTL_RESET) lock_err_d = 1'b0;
    end

    always_comb begin
        rd_valid_d = rx_c0.mmioRdValid;
        rd_tid_d   = rx_c0.hdr.tid;
        rd_data_d  = '0;
        case (byte_off)
            OFF_DFH:       rd_data_d = DFH_VALUE;
            OFF_AFU_ID_L:  rd_data_d = AFU_ID[63:0];
            OFF_AFU_ID_H:  rd_data_d = AFU_ID[127:64];
            OFF_HC_STATUS: rd_data_d = {60'b0, lock_err_q, ctl_state};
            OFF_DSM_BASE:  rd_data_d = dsm_q;
            default:       rd_data_d = '0;
        endcase
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (byte_off == OFF_BUF_BASE + 18'(16 * i)) rd_data_d = buf_q[i].address;
            if (byte_off == OFF_BUF_BASE + 18'(16 * i) + 18'h8) rd_data_d = {32'b0, buf_q[i].size};
        end
    end

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            dsm_q      <= '0;
            lock_err_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_tid_q   <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < NUM_BUFFERS; i++) buf_q[i] <= '0;
        end else begin
            dsm_q      <= dsm_d;
            buf_q      <= buf_d;
            lock_err_q <= lock_err_d;
            rd_valid_q <= rd_valid_d;
            rd_tid_q   <= rd_tid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // A reset arriving in the response cycle suppresses the pending answer.
    always_comb begin
        tx_c2             = '0;
        tx_c2.mmioRdValid = rd_valid_q && !SoftReset;
        tx_c2.hdr.tid     = rd_tid_q;
        tx_c2.data        = rd_data_q;
    end

    assign hc_dsm_base = dsm_q;
    assign hc_buffer   = buf_q;
    assign hc_afu_rst  = (ctl_state == S_CTL_RESET);
    assign hc_running  = (ctl_state == S_CTL_RUN);

endmodule

// File: tb/tb_hc_csr_bank.sv
// Directed plus randomized MMIO traffic against hc_csr_bank (4 buffers),
// checked against a register-map reference model.
module tb_hc_csr_bank;
    import hc_csr_pkg::*;

    localparam int           NB  = 4;
    localparam logic [127:0] AFU = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam int ST_RESET = 0, ST_IDLE = 1, ST_RUN = 2, ST_STOP = 3;

    logic           clk = 1'b0;
    logic           soft_reset;
    t_if_ccip_c0_Rx rx_c0;
    t_if_ccip_c2_Tx tx_c2;
    logic [63:0]    hc_dsm_base;
    t_hc_buffer     hc_buffer [NB];
    logic           hc_afu_rst, hc_start, hc_stop, hc_running;

    int tests_run = 0;
    int tests_failed = 0;

    // reference model
    int          m_state;
    bit          m_lock, m_start, m_stop;
    logic [63:0] m_dsm;
    logic [63:0] m_addr [NB];
    logic [31:0] m_size [NB];
    logic [127:0] afu_v = AFU;
    logic [31:0] codes [6] = '{32'h0, 32'h1, 32'h3, 32'h7, 32'h3, 32'h5};

    hc_csr_bank #(.NUM_BUFFERS(NB), .AFU_ID(AFU)) dut (
        .clk         (clk),
        .SoftReset   (soft_reset),
        .rx_c0       (rx_c0),
        .tx_c2       (tx_c2),
        .hc_dsm_base (hc_dsm_base),
        .hc_buffer   (hc_buffer),
        .hc_afu_rst  (hc_afu_rst),
        .hc_start    (hc_start),
        .hc_stop     (hc_stop),
        .hc_running  (hc_running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_RESET; m_lock = 0; m_start = 0; m_stop = 0; m_dsm = '0;
        for (int i = 0; i < NB; i++) begin m_addr[i] = '0; m_size[i] = '0; end
    endtask

    task automatic model_ctl(input logic [31:0] code);
        case (code)
            32'h0: begin m_state = ST_RESET; m_lock = 0; end
            32'h1: if (m_state == ST_RESET) m_state = ST_IDLE;
            32'h3: if (m_state == ST_IDLE || m_state == ST_STOP) begin m_state = ST_RUN; m_start = 1; end
            32'h7: if (m_state == ST_RUN) begin m_state = ST_STOP; m_stop = 1; end
            default: ;
        endcase
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input bit len8, input bit hi);
        if (len8) return d;
        return hi ? {d[31:0], old[31:0]} : {old[63:32], d[31:0]};
    endfunction

    task automatic model_write(input logic [17:0] boff, input logic [63:0] d, input bit len8);
        logic [17:0] o8;
        logic [63:0] nv;
        bit hi;
        int i;
        o8 = boff & 18'h3FFF8;
        hi = boff[2];
        i  = int'((o8 - 18'h120) >> 4);
        if (o8 == 18'h118) begin
            if (len8 || !hi) model_ctl(d[31:0]);
        end else if (o8 == 18'h110 || (o8 >= 18'h120 && o8 < 18'h120 + 18'(16 * NB))) begin
            if (m_state == ST_RUN) m_lock = 1;
            else if (o8 == 18'h110) m_dsm = merge(m_dsm, d, len8, hi);
            else if (!o8[3]) m_addr[i] = merge(m_addr[i], d, len8, hi);
            else begin
                nv = merge({32'b0, m_size[i]}, d, len8, hi);
                m_size[i] = nv[31:0];
            end
        end
    endtask

    function automatic logic [63:0] model_read(input logic [17:0] boff);
        logic [17:0] o8;
        int i;
        o8 = boff & 18'h3FFF8;
        i  = int'((o8 - 18'h120) >> 4);
        if (o8 == 18'h000) return 64'h1000_0000_0000_1000;
        if (o8 == 18'h008) return afu_v[63:0];
        if (o8 == 18'h010) return afu_v[127:64];
        if (o8 == 18'h100) return {60'b0, m_lock, 3'(m_state)};
        if (o8 == 18'h110) return m_dsm;
        if (o8 >= 18'h120 && o8 < 18'h120 + 18'(16 * NB))
            return o8[3] ? {32'b0, m_size[i]} : m_addr[i];
        return 64'h0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " dsm"}, hc_dsm_base, m_dsm);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s buf%0d.addr", tag, i), hc_buffer[i].address, m_addr[i]);
            check($sformatf("%s buf%0d.size", tag, i), {32'b0, hc_buffer[i].size}, {32'b0, m_size[i]});
        end
        check({tag, " afu_rst"}, {63'b0, hc_afu_rst}, {63'b0, m_state == ST_RESET});
        check({tag, " running"}, {63'b0, hc_running}, {63'b0, m_state == ST_RUN});
        check({tag, " start"}, {63'b0, hc_start}, {63'b0, m_start});
        check({tag, " stop"}, {63'b0, hc_stop}, {63'b0, m_stop});
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [17:0] boff, input logic [63:0] d,
                         input bit len8, input logic [8:0] tid);
        rx_c0 = '0;
        rx_c0.hdr.address = boff[17:2];
        rx_c0.hdr.length  = len8 ? 2'b01 : 2'b00;
        rx_c0.hdr.tid     = tid;
        rx_c0.data        = {448'b0, d};
        rx_c0.mmioRdValid = rd;
        rx_c0.mmioWrValid = wr;
    endtask

    task automatic step(input bit rd, input bit wr, input logic [17:0] boff, input logic [63:0] d,
                        input bit len8, input logic [8:0] tid, input string tag);
        logic [63:0] exp_data;
        exp_data = model_read(boff);
        drive(rd, wr, boff, d, len8, tid);
        @(posedge clk); #1;
        rx_c0 = '0;
        m_start = 0; m_stop = 0;
        if (wr && !rd) model_write(boff, d, len8);
        check({tag, " rd_valid"}, {63'b0, tx_c2.mmioRdValid}, {63'b0, rd});
        if (rd) begin
            check({tag, " rd_tid"}, {55'b0, tx_c2.hdr.tid}, {55'b0, tid});
            check({tag, " rd_data"}, tx_c2.data, exp_data);
        end
        check_outputs(tag);
    endtask

    task automatic wr(input logic [17:0] boff, input logic [63:0] d, input bit len8, input string tag);
        step(0, 1, boff, d, len8, 9'h0, tag);
    endtask

    task automatic rd(input logic [17:0] boff, input logic [8:0] tid, input string tag);
        step(1, 0, boff, 64'h0, 1, tid, tag);
    endtask

    task automatic do_reset(input string tag);
        soft_reset = 1; rx_c0 = '0;
        repeat (2) @(posedge clk);
        #1;
        soft_reset = 0;
        model_reset();
        check({tag, " rd_valid"}, {63'b0, tx_c2.mmioRdValid}, 64'h0);
        check_outputs(tag);
    endtask

    initial begin
        logic [17:0] boff;
        logic [63:0] d;
        bit          l8;
        int unsigned sel;

        soft_reset = 1; rx_c0 = '0;
        model_reset();
        do_reset("reset");

        rd(18'h100, 9'h011, "status_after_reset");
        rd(18'h000, 9'h022, "dfh");
        rd(18'h008, 9'h1A5, "afu_id_lo");
        rd(18'h010, 9'h033, "afu_id_hi");

        wr(18'h118, 64'h3, 1, "start_in_reset");
        rd(18'h100, 9'h001, "status_still_reset");

        wr(18'h118, 64'h1, 1, "init");
        wr(18'h150, 64'hDEAD_0000, 1, "buf3_addr");
        wr(18'h158, 64'h40, 1, "buf3_size");
        wr(18'h160, 64'hFFFF_FFFF_FFFF_FFFF, 1, "unmapped_wr");
        rd(18'h160, 9'h044, "unmapped_rd");
        rd(18'h150, 9'h045, "buf3_addr_rd");
        wr(18'h110, 64'h1111_1111, 0, "dsm_lo32");
        wr(18'h114, 64'h2222_2222, 0, "dsm_hi32");
        wr(18'h12C, 64'h5555_5555, 0, "size_hi32_ignored");
        rd(18'h118, 9'h046, "control_rd_zero");

        wr(18'h118, 64'h3, 1, "start");
        step(0, 0, 18'h0, 64'h0, 1, 9'h0, "after_start");
        rd(18'h100, 9'h050, "status_run");
        wr(18'h120, 64'h1234, 1, "locked_write");
        rd(18'h100, 9'h051, "status_lock_err");
        wr(18'h118, 64'h3, 1, "start_while_running");

        wr(18'h118, 64'h7, 1, "stop");
        rd(18'h100, 9'h052, "status_stop");
        step(1, 1, 18'h110, 64'hABCD, 1, 9'h053, "rd_wr_collision");
        wr(18'h118, 64'h3, 1, "restart");
        wr(18'h118, 64'h0, 1, "ctl_reset");
        rd(18'h100, 9'h054, "status_cleared");

        // reset arriving together with a read request
        wr(18'h118, 64'h1, 1, "init2");
        wr(18'h110, 64'hCAFE, 1, "dsm2");
        wr(18'h118, 64'h3, 1, "start2");
        drive(1, 0, 18'h100, 64'h0, 1, 9'h0AA);
        soft_reset = 1;
        @(posedge clk); #1;
        rx_c0 = '0; soft_reset = 0;
        model_reset();
        check("rst_with_req rd_valid", {63'b0, tx_c2.mmioRdValid}, 64'h0);
        check_outputs("rst_with_req");

        // reset arriving in the response cycle
        wr(18'h118, 64'h1, 1, "init3");
        wr(18'h128, 64'h77, 1, "size3");
        wr(18'h118, 64'h3, 1, "start3");
        drive(1, 0, 18'h128, 64'h0, 1, 9'h0BB);
        @(posedge clk); #1;
        rx_c0 = '0; soft_reset = 1;
        #1;
        check("rst_in_rsp rd_valid", {63'b0, tx_c2.mmioRdValid}, 64'h0);
        @(posedge clk); #1;
        soft_reset = 0;
        model_reset();
        check("rst_in_rsp rd_valid_after", {63'b0, tx_c2.mmioRdValid}, 64'h0);
        check_outputs("rst_in_rsp");
        rd(18'h110, 9'h0CC, "dsm_zero_after_rst");
        rd(18'h128, 9'h0CD, "size_zero_after_rst");

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            d   = {$urandom, $urandom};
            l8  = 1'($urandom_range(0, 1));
            if (sel <= 2) begin
                boff = ($urandom_range(0, 4) == 0) ? 18'h11C : 18'h118;
                d    = {32'b0, codes[$urandom_range(0, 5)]};
                wr(boff, d, l8, "rand_ctl");
            end else if (sel <= 5) begin
                boff = 18'($urandom_range(18'h100 >> 2, 18'h170 >> 2)) << 2;
                if (l8) boff = boff & 18'h3FFF8;
                wr(boff, d, l8, "rand_wr");
            end else if (sel <= 8) begin
                boff = 18'($urandom_range(0, 18'h170 >> 2)) << 2;
                rd(boff, 9'($urandom_range(0, 511)), "rand_rd");
            end else begin
                boff = 18'($urandom_range(18'h110 >> 3, 18'h150 >> 3)) << 3;
                step(1, 1, boff, d, 1, 9'($urandom_range(0, 511)), "rand_both");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
